// File: rtl/dmem_store_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory unit and its store buffer.
package dmem_store_unit_pkg;

    localparam int WIDTH          = 32;
    localparam int MEM_ADDR_WIDTH = 7;
    localparam int MEM_CTRL_WIDTH = 2;
    localparam int SB_DEPTH       = 4;

    // Bit positions inside the CPU's mem_ctrl bus
    localparam int MEM_WRITE_BIT = 1;
    localparam int MEM_READ_BIT  = 0;

endpackage

// File: rtl/dmem_store_unit_store_buffer.sv
// Circular FIFO of pending stores with a youngest-match lookup used for
// load forwarding. Head/tail wrap modulo DEPTH; occupancy is tracked separately.
module dmem_store_unit_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 7,
    parameter int DW    = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [AW-1:0]    push_addr,
    input  logic [DW-1:0]    push_data,
    input  logic             pop,
    output logic [AW-1:0]    head_addr,
    output logic [DW-1:0]    head_data,
    input  logic [AW-1:0]    lookup_addr,
    output logic             hit,
    output logic [DW-1:0]    hit_data,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: entry storage is deliberately left out of reset; validity comes
    // from head/count alone, so clearing the payload would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= push_addr;
            data_q[tail_q] <= push_data;
        end
    end

    // Scan oldest to youngest so the last match (the youngest) wins.
    // NOTE: every output of this block gets a default first so no path
    // leaves it holding a stale value, which would otherwise infer a latch.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (CNT_W'(i) < count_q && addr_q[idx] == lookup_addr) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

    assign head_addr = addr_q[head_q];
    assign head_data = data_q[head_q];
    assign count     = count_q;
    assign full      = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/dmem_store_unit.sv
// MEM-stage data memory: 128-word array fed through a store buffer, with
// same-cycle load forwarding. Define DMEM_DBG_PORT_EN for the debug/DMA write port.
module dmem_store_unit #(
    parameter int SB_DEPTH       = dmem_store_unit_pkg::SB_DEPTH,
    parameter int WIDTH          = dmem_store_unit_pkg::WIDTH,
    parameter int MEM_ADDR_WIDTH = dmem_store_unit_pkg::MEM_ADDR_WIDTH
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic [1:0]                      mem_ctrl_i,
    input  logic [WIDTH-1:0]                addr_i,
    input  logic [WIDTH-1:0]                wdata_i,
    output logic [WIDTH-1:0]                rdata_o,
`ifdef DMEM_DBG_PORT_EN
    input  logic                            dbg_we_i,
    input  logic [MEM_ADDR_WIDTH-1:0]       dbg_addr_i,
    input  logic [WIDTH-1:0]                dbg_wdata_i,
`endif
    output logic [$clog2(SB_DEPTH+1)-1:0]   sb_count_o,
    output logic                            sb_full_o,
    output logic                            overflow_o
);

    import dmem_store_unit_pkg::*;

    localparam int AW = MEM_ADDR_WIDTH;

    logic [WIDTH-1:0] mem [2**AW];

    logic             dbg_we;
    logic [AW-1:0]    dbg_addr;
    logic [WIDTH-1:0] dbg_wdata;
    logic             store, drain, accept, hit, full;
    logic [AW-1:0]    head_addr;
    logic [WIDTH-1:0] head_data, hit_data;
    logic             unused_bits;

`ifdef DMEM_DBG_PORT_EN
    assign dbg_we    = dbg_we_i;
    assign dbg_addr  = dbg_addr_i;
    assign dbg_wdata = dbg_wdata_i;
`else
    assign dbg_we    = 1'b0;
    assign dbg_addr  = '0;
    assign dbg_wdata = '0;
`endif

    // Debug owns the array port; otherwise the head drains whenever present.
    assign store  = mem_ctrl_i[MEM_WRITE_BIT];
    assign drain  = (sb_count_o != '0) && !dbg_we;
    assign accept = store && (!full || drain);

    dmem_store_unit_store_buffer #(
        .DEPTH (SB_DEPTH),
        .AW    (AW),
        .DW    (WIDTH)
    ) u_store_buffer (
        .clk         (clk_i),
        .rst_n       (rst_n_i),
        .push        (accept),
        .push_addr   (addr_i[AW-1:0]),
        .push_data   (wdata_i),
        .pop         (drain),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .lookup_addr (addr_i[AW-1:0]),
        .hit         (hit),
        .hit_data    (hit_data),
        .count       (sb_count_o),
        .full        (full)
    );

    // NOTE: sequential state always uses non-blocking assignment so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i) begin
        if (dbg_we)
            mem[dbg_addr] <= dbg_wdata;
        else if (drain)
            mem[head_addr] <= head_data;
    end

    // Pending entries shadow the array, including the one draining this edge.
    assign rdata_o   = hit ? hit_data : mem[addr_i[AW-1:0]];
    assign sb_full_o = full;

`ifdef DMEM_DBG_PORT_EN
    logic overflow_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            overflow_q <= 1'b0;
        else if (store && full && !drain)
            overflow_q <= 1'b1;
    end

    assign overflow_o = overflow_q;
`else
    assign overflow_o = 1'b0;
`endif

    // Loads never stall and upper address bits are ignored by design.
    assign unused_bits = ^{addr_i[WIDTH-1:AW], mem_ctrl_i[MEM_READ_BIT]};

endmodule

// File: tb/tb_dmem_store_unit.sv
// Directed self-checking bench for dmem_store_unit; exercises the debug-port
// scenarios when DMEM_DBG_PORT_EN is defined, the always-drain build otherwise.
module tb_dmem_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mem_ctrl;
    logic [31:0] addr, wdata, rdata;
    logic [2:0]  sb_count;
    logic        sb_full, overflow;
    int          n_checks = 0;
    int          n_fail   = 0;
`ifdef DMEM_DBG_PORT_EN
    logic        dbg_we = 1'b0;
    logic [6:0]  dbg_addr = 7'd100;
    logic [31:0] dbg_wdata = 32'h0;
`endif

    always #5 clk = ~clk;

    dmem_store_unit dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .mem_ctrl_i  (mem_ctrl),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .rdata_o     (rdata),
`ifdef DMEM_DBG_PORT_EN
        .dbg_we_i    (dbg_we),
        .dbg_addr_i  (dbg_addr),
        .dbg_wdata_i (dbg_wdata),
`endif
        .sb_count_o  (sb_count),
        .sb_full_o   (sb_full),
        .overflow_o  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled after a further 1.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d);
        mem_ctrl = c;
        addr     = a;
        wdata    = d;
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle, held across one edge, released away from it.
    task automatic pulse_reset_checked();
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_count", 32'(sb_count), 32'd0);
        check("rst_mid_full",  32'(sb_full),  32'd0);
        check("rst_mid_ovf",   32'(overflow), 32'd0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(2'b00, 32'h0, 32'h0);
        #10;
        check("reset_count", 32'(sb_count), 32'd0);
        check("reset_full",  32'(sb_full),  32'd0);
        check("reset_ovf",   32'(overflow), 32'd0);
        release_reset();
        step();

`ifdef DMEM_DBG_PORT_EN
        // Forwarding, then drain into the array
        drive(2'b10, 32'hFFFF_FF85, 32'hDEADBEEF);
        step();
        check("fwd_count", 32'(sb_count), 32'd1);
        drive(2'b01, 32'd5, 32'h0);
        check("fwd_load", rdata, 32'hDEADBEEF);
        step();
        check("fwd_drained", 32'(sb_count), 32'd0);
        check("fwd_array", rdata, 32'hDEADBEEF);

        // Youngest match while debug holds the array port
        dbg_we = 1'b1;
        drive(2'b10, 32'd3, 32'h11); step();
        drive(2'b10, 32'd3, 32'h22); step();
        check("young_count", 32'(sb_count), 32'd2);
        drive(2'b01, 32'd3, 32'h0);
        check("young_load", rdata, 32'h22);
        dbg_we = 1'b0;
        step(); step();
        check("young_drained", 32'(sb_count), 32'd0);
        check("young_array", rdata, 32'h22);

        // Fill to full, fifth store dropped
        dbg_we = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(2'b10, 32'(40 + i), 32'(8'hA0 + i));
            step();
            if (i == 3) begin
                check("full_count", 32'(sb_count), 32'd4);
                check("full_flag",  32'(sb_full),  32'd1);
                check("full_ovf0",  32'(overflow), 32'd0);
            end
        end
        check("drop_count", 32'(sb_count), 32'd4);
        check("drop_ovf",   32'(overflow), 32'd1);
        dbg_we = 1'b0;
        drive(2'b00, 32'd0, 32'd0);
        repeat (4) step();
        check("drop_drained", 32'(sb_count), 32'd0);
        check("drop_sticky",  32'(overflow), 32'd1);
        drive(2'b01, 32'd43, 32'd0);
        check("drop_arr43", rdata, 32'hA3);

        // Full with a drain: store accepted, FIFO order kept across wrap
        rst_n = 1'b0; #2 rst_n = 1'b1;
        check("ovf_cleared", 32'(overflow), 32'd0);
        dbg_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(2'b10, 32'(50 + i), 32'(8'hB0 + i));
            step();
        end
        dbg_we = 1'b0;
        drive(2'b10, 32'd50, 32'hC0);
        step();
        check("fwd_full_count", 32'(sb_count), 32'd4);
        check("fwd_full_ovf",   32'(overflow), 32'd0);
        drive(2'b01, 32'd50, 32'd0);
        check("wrap_fwd50", rdata, 32'hC0);
        repeat (4) step();
        check("wrap_drained", 32'(sb_count), 32'd0);
        check("wrap_arr50",   rdata, 32'hC0);
        drive(2'b01, 32'd51, 32'd0);
        check("wrap_arr51",   rdata, 32'hB1);

        // Debug write to an address still pending in the buffer
        dbg_we = 1'b1;
        drive(2'b10, 32'd9, 32'hAA); step();
        dbg_addr = 7'd9; dbg_wdata = 32'hBB;
        drive(2'b00, 32'd9, 32'd0); step();
        check("dbg_pending_count", 32'(sb_count), 32'd1);
        dbg_we = 1'b0; dbg_addr = 7'd100;
        step();
        drive(2'b01, 32'd9, 32'd0);
        check("dbg_program_order", rdata, 32'hAA);

        // Reset with three stores pending: array keeps old contents
        dbg_we = 1'b1;
        drive(2'b10, 32'd9,  32'h99); step();
        drive(2'b10, 32'd50, 32'h55); step();
        drive(2'b10, 32'd3,  32'h33); step();
        check("rst_pending3", 32'(sb_count), 32'd3);
        drive(2'b01, 32'd9, 32'd0);
        pulse_reset_checked();
        check("rst_old9", rdata, 32'hAA);
        addr = 32'd50; #1;
        check("rst_old50", rdata, 32'hC0);
        addr = 32'd3; #1;
        check("rst_old3", rdata, 32'h22);
        dbg_we = 1'b0;
        release_reset();
`else
        // Forwarding, then drain into the array; upper address bits ignored
        drive(2'b10, 32'hFFFF_FF85, 32'hDEADBEEF);
        step();
        check("fwd_count", 32'(sb_count), 32'd1);
        drive(2'b01, 32'd5, 32'h0);
        check("fwd_load", rdata, 32'hDEADBEEF);
        step();
        check("fwd_drained", 32'(sb_count), 32'd0);
        check("fwd_array", rdata, 32'hDEADBEEF);

        // Back-to-back stores to one address: enqueue and drain together
        drive(2'b10, 32'd3, 32'h11); step();
        drive(2'b10, 32'd3, 32'h22); step();
        check("b2b_count", 32'(sb_count), 32'd1);
        drive(2'b01, 32'd3, 32'h0);
        check("b2b_load", rdata, 32'h22);
        step();
        check("b2b_drained", 32'(sb_count), 32'd0);
        check("b2b_array", rdata, 32'h22);

        // Store stream longer than the buffer: occupancy never exceeds one
        for (int i = 0; i < 6; i++) begin
            drive(2'b10, 32'(10 + i), 32'(32'h1000 + i));
            step();
            check("stream_count", 32'(sb_count), 32'd1);
        end
        check("stream_full", 32'(sb_full),  32'd0);
        check("stream_ovf",  32'(overflow), 32'd0);
        drive(2'b00, 32'd0, 32'd0);
        step();
        for (int i = 0; i < 6; i++) begin
            drive(2'b01, 32'(10 + i), 32'd0);
            check("stream_array", rdata, 32'(32'h1000 + i));
        end

        // Pending store shadows an older array value
        drive(2'b10, 32'd5, 32'h5555); step();
        drive(2'b01, 32'd5, 32'd0);
        check("shadow_load", rdata, 32'h5555);
        step();

        // Both control bits set behaves as a store
        drive(2'b11, 32'd7, 32'h77); step();
        check("both_count", 32'(sb_count), 32'd1);
        drive(2'b01, 32'd7, 32'd0);
        check("both_fwd", rdata, 32'h77);
        step();
        check("both_array", rdata, 32'h77);

        // Reset while a store is pending: it never reaches the array
        drive(2'b10, 32'd20, 32'h1111); step();
        drive(2'b10, 32'd20, 32'h2222); step();
        check("rst_pending", 32'(sb_count), 32'd1);
        drive(2'b01, 32'd20, 32'd0);
        pulse_reset_checked();
        check("rst_old20", rdata, 32'h1111);
        release_reset();
`endif

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
